booth_multiplier: RTL and testbench

- Sequential signed 32x32 multiplier; the counterpart of the iterative divider in the multdiv unit.
- Shares the multdiv operand, control and ready interface: data_operandA, data_operandB, ctrl_MULT, ctrl_DIV, data_result, data_exception and data_resultRDY.
- Latches both operands on a start pulse and iterates a Booth-recoded add/shift datapath.
- Presents the low 32 product bits with an overflow exception and a one-cycle ready pulse.

---
 rtl/booth_multiplier.sv | 141 ++++++++++++++
 tb/tb_booth_multiplier.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential signed 32x32 Booth multiplier, radix-4 by default (17-cycle latency);
// defining MULT_RADIX2_EN selects a radix-2 datapath (33-cycle latency). ctrl_DIV aborts, ctrl_MULT restarts.
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

`ifdef MULT_RADIX2_EN
    localparam int N = WIDTH;
`else
    localparam int N = WIDTH / 2;
`endif
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH+1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [WIDTH+1:0]   a_ext;
    logic [WIDTH+1:0]   pp;
    logic [WIDTH+1:0]   sum;
    logic [2*WIDTH-1:0] product;

    assign a_ext   = {{2{a_q[WIDTH-1]}}, a_q};
    assign sum     = acc_q + pp;
    assign product = {acc_q[WIDTH-1:0], mq_q};

    // Two guard bits in acc keep +-2A and the 2^31 case of -A from wrapping.
    always_comb begin
        pp = '0;
`ifdef MULT_RADIX2_EN
        case ({mq_q[0], qm1_q})
            2'b01:   pp = a_ext;
            2'b10:   pp = -a_ext;
            default: pp = '0;
        endcase
`else
        case ({mq_q[1:0], qm1_q})
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;
        if (ctrl_DIV) begin
            state_d = IDLE;
        end else if (ctrl_MULT) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = data_operandA;
            mq_d    = data_operandB;
            acc_d   = '0;
            qm1_d   = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
`ifdef MULT_RADIX2_EN
                    acc_d = {sum[WIDTH+1], sum[WIDTH+1:1]};
                    mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                    qm1_d = mq_q[0];
`else
                    acc_d = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
                    mq_d  = {sum[1:0], mq_q[WIDTH-1:2]};
                    qm1_d = mq_q[1];
`endif
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    res_d   = product[WIDTH-1:0];
                    exc_d   = ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));
                    rdy_d   = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: directed vectors, restart, abort and reset cases.
module tb_booth_multiplier;

`ifdef MULT_RADIX2_EN
    localparam int NLAT = 33;
`else
    localparam int NLAT = 17;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    booth_multiplier #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   rdy_cnt = 0;
    logic prev_rdy = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse is matched against the oldest outstanding expectation.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            rdy_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", data_result, e.res);
                chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
                chk("latency", cyc, e.due);
                chk("rdy_width", {31'd0, prev_rdy}, 32'd0);
            end
        end
        prev_rdy = data_resultRDY;
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input bit abandon);
        exp_t e;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = 1'b1;
        if (abandon && sb.size() > 0) void'(sb.pop_back());
        e.res = res;
        e.exc = exc;
        e.due = cyc + NLAT + 1;
        sb.push_back(e);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'hCAFE_F00D;
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc);
        start(a, b, res, exc, 1'b0);
        repeat (NLAT + 3) @(negedge clock);
        chk("held_result", data_result, res);
        chk("held_exception", {31'd0, data_exception}, {31'd0, exc});
        chk("sb_drained", sb.size(), 0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[7];
    int   rdy_before;

    initial begin
        vecs[0] = '{32'd6,          32'd7,          32'd42,         1'b0};
        vecs[1] = '{32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  1'b0};
        vecs[2] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[3] = '{32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1};
        vecs[4] = '{32'h0001_0000,  32'hFFFF_0000,  32'h0000_0000,  1'b1};
        vecs[5] = '{32'h0000_1234,  32'hFFFF_FFF0,  32'hFFFE_DCC0,  1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1'b0};

        repeat (3) @(negedge clock);
        chk("reset_result", data_result, 32'd0);
        chk("reset_exception", {31'd0, data_exception}, 32'd0);
        chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        chk("idle_no_rdy", rdy_cnt, 0);
        chk("idle_result", data_result, 32'd0);

        foreach (vecs[i]) run(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);

        // Restart: 6x7 abandoned by a 9x9 start five cycles later.
        rdy_before = rdy_cnt;
        start(32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        start(32'd9, 32'd9, 32'd81, 1'b0, 1'b1);
        repeat (NLAT + 3) @(negedge clock);
        chk("restart_single_rdy", rdy_cnt - rdy_before, 1);
        chk("restart_result", data_result, 32'd81);
        chk("restart_sb", sb.size(), 0);

        // Abort by ctrl_DIV: outputs keep the 81 from before.
        rdy_before = rdy_cnt;
        start(32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        ctrl_DIV = 1'b1;
        void'(sb.pop_back());
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (NLAT + 5) @(negedge clock);
        chk("abort_no_rdy", rdy_cnt - rdy_before, 0);
        chk("abort_result", data_result, 32'd81);
        chk("abort_exception", {31'd0, data_exception}, 32'd0);

        // Mid-operation reset clears the outputs.
        rdy_before = rdy_cnt;
        start(32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        repeat (6) @(negedge clock);
        reset_n = 1'b0;
        void'(sb.pop_back());
        @(negedge clock);
        reset_n = 1'b1;
        chk("midreset_result", data_result, 32'd0);
        repeat (NLAT + 5) @(negedge clock);
        chk("midreset_no_rdy", rdy_cnt - rdy_before, 0);
        chk("midreset_result_held", data_result, 32'd0);
        chk("midreset_exception", {31'd0, data_exception}, 32'd0);

        // Back-to-back sanity after reset.
        run(32'd6, 32'd7, 32'd42, 1'b0);

        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
